// File: rtl/ram_slave_pkg.sv
// Shared types and constants for the ram_slave request/acknowledge memory.
package ram_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } state_t;

  // wr_ni encoding
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

endpackage

// File: rtl/ram_slave_if.sv
// Request/acknowledge bus between one requester and ram_slave.
// Optional rd_err signal exists only when RAM_SLAVE_UNINIT_CHK_EN is defined.
interface ram_slave_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DELAY_W    = 4
);
  // Handshake: the master raises rq with address/wr_ni/dataW/delay and keeps rq high
  // until it sees ack; the slave pulses ack for one cycle (dataR valid with it).
  // Dropping rq before ack aborts the transaction with no memory access.
  logic [ADDR_WIDTH-1:0] address;
  logic                  rq;
  logic                  wr_ni;
  logic [DATA_WIDTH-1:0] dataW;
  logic [DELAY_W-1:0]    delay;
  logic                  ack;
  logic [DATA_WIDTH-1:0] dataR;
  logic                  busy;
`ifdef RAM_SLAVE_UNINIT_CHK_EN
  logic                  rd_err;
`endif

  modport master (
    output address, rq, wr_ni, dataW, delay,
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    input  rd_err,
`endif
    input  ack, dataR, busy
  );

  modport slave (
    input  address, rq, wr_ni, dataW, delay,
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    output rd_err,
`endif
    output ack, dataR, busy
  );
endinterface

// File: rtl/ram_slave_delay_cnt.sv
// Loadable down-counter timing the acknowledge delay; last flags a count of one.
module ram_slave_delay_cnt #(
  parameter int DELAY_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  input  logic               en,
  output logic               last
);
  logic [DELAY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)    cnt_d = load_val;
    else if (en) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign last = (cnt_q == {{(DELAY_W-1){1'b0}}, 1'b1});
endmodule

// File: rtl/ram_slave.sv
// Single-port RAM slave with per-transaction programmable ack delay and abort.
// Define RAM_SLAVE_UNINIT_CHK_EN to add uninitialised-read detection (rd_err).
module ram_slave
  import ram_slave_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DELAY_W    = 4
) (
  input  logic   clk,
  input  logic   reset_n,
  ram_slave_if.slave bus,
  output state_t state_dbg
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_ni_q, wr_ni_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] data_r_q, data_r_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  cnt_load, cnt_en, cnt_last;
  logic                  access, mem_we;
`ifdef RAM_SLAVE_UNINIT_CHK_EN
  logic [DEPTH-1:0]      valid_q, valid_d;
  logic                  rd_err_q, rd_err_d;
`endif

  ram_slave_delay_cnt #(.DELAY_W(DELAY_W)) u_delay_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (bus.delay),
    .en       (cnt_en),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    unique case (state_q)
      IDLE: if (bus.rq) begin
        cnt_load = 1'b1;
        state_d  = (bus.delay == '0) ? ACK : WAIT;
      end
      WAIT: begin
        if (!bus.rq)       state_d = IDLE;
        else if (cnt_last) state_d = ACK;
        else               cnt_en  = 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ack   = (state_q == ACK);
    bus.busy  = (state_q != IDLE);
    bus.dataR = data_r_q;
    state_dbg = state_q;
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    bus.rd_err = rd_err_q;
`endif
  end

  // The _d copies equal the live inputs on the sampling edge, so a zero-delay
  // access entering ACK straight from IDLE still uses the captured request.
  always_comb begin
    addr_d  = addr_q;
    wr_ni_d = wr_ni_q;
    data_d  = data_q;
    if (state_q == IDLE && bus.rq) begin
      addr_d  = bus.address;
      wr_ni_d = bus.wr_ni;
      data_d  = bus.dataW;
    end
    access   = (state_d == ACK) && (state_q != ACK);
    mem_we   = access && (wr_ni_d == WR) && reset_n;
    data_r_d = data_r_q;
    if (access && wr_ni_d == RD) data_r_d = mem_q[addr_d];
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    valid_d  = valid_q;
    rd_err_d = 1'b0;
    if (mem_we) valid_d[addr_d] = 1'b1;
    if (access && wr_ni_d == RD && !valid_q[addr_d]) begin
      data_r_d = '0;
      rd_err_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q   <= '0;
      wr_ni_q  <= RD;
      data_q   <= '0;
      data_r_q <= '0;
`ifdef RAM_SLAVE_UNINIT_CHK_EN
      valid_q  <= '0;
      rd_err_q <= 1'b0;
`endif
    end else begin
      addr_q   <= addr_d;
      wr_ni_q  <= wr_ni_d;
      data_q   <= data_d;
      data_r_q <= data_r_d;
`ifdef RAM_SLAVE_UNINIT_CHK_EN
      valid_q  <= valid_d;
      rd_err_q <= rd_err_d;
`endif
    end
  end

  // Memory contents deliberately have no reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[addr_d] <= data_d;
  end
endmodule

// File: tb/tb_ram_slave.sv
// Self-checking bench for ram_slave: latency, abort, back-to-back and reset behaviour.
module tb_ram_slave;
  import ram_slave_pkg::*;

  logic   clk = 1'b0;
  logic   reset_n = 1'b0;
  state_t state_dbg;
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;

  logic [7:0] exp_q[$];
  logic [7:0] model[16];
  bit         model_valid[16];

  ram_slave_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DELAY_W(4)) bus ();

  ram_slave #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .DELAY_W(4)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- driver tasks ----------------
  task automatic drive_in(input logic wr, input logic [3:0] a, input logic [7:0] d,
                          input logic [3:0] dly, output logic exp_err);
    exp_err     = 1'b0;
    bus.address = a;
    bus.wr_ni   = wr;
    bus.dataW   = d;
    bus.delay   = dly;
    bus.rq      = 1'b1;
    if (wr == RD) begin
`ifdef RAM_SLAVE_UNINIT_CHK_EN
      if (model_valid[a]) exp_q.push_back(model[a]);
      else begin
        exp_q.push_back(8'h00);
        exp_err = 1'b1;
      end
`else
      exp_q.push_back(model[a]);
`endif
    end else begin
      model[a]       = d;
      model_valid[a] = 1'b1;
    end
  endtask

  task automatic do_txn(input logic wr, input logic [3:0] a, input logic [7:0] d,
                        input logic [3:0] dly, input string name);
    logic       exp_err;
    logic [7:0] exp_d;
    bit         seen = 0;
    bit         busy_bad = 0;
    int         lat = -1;
    drive_in(wr, a, d, dly, exp_err);
    @(posedge clk);
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) begin
        seen = 1;
        lat  = i;
        break;
      end
      if (bus.busy !== 1'b1) busy_bad = 1;
    end
    checks++;
    if (!seen || lat != int'(dly)) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles (seen=%0d), expected %0d", name, lat, seen, dly);
    end
    checks++;
    if (busy_bad || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy: dropped before/at ack, expected high throughout", name);
    end
    if (wr == RD && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      checks++;
      if (bus.dataR !== exp_d) begin
        errors++;
        $display("FAIL %s dataR: got %h expected %h", name, bus.dataR, exp_d);
      end
    end
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    checks++;
    if (bus.rd_err !== (seen ? exp_err : 1'b0)) begin
      errors++;
      $display("FAIL %s rd_err at ack: got %b expected %b", name, bus.rd_err, exp_err);
    end
`endif
    bus.rq = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin
      errors++;
      $display("FAIL %s after ack: busy=%b ack=%b expected 0 0", name, bus.busy, bus.ack);
    end
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    checks++;
    if (bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL %s rd_err after ack: got %b expected 0", name, bus.rd_err);
    end
`endif
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.rq = 1'b0; bus.address = '0; bus.wr_ni = RD; bus.dataW = '0; bus.delay = '0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.dataR !== 8'h00 || state_dbg !== IDLE) begin
      errors++;
      $display("FAIL reset: ack=%b busy=%b dataR=%h state=%0d expected 0 0 00 0",
               bus.ack, bus.busy, bus.dataR, state_dbg);
    end
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    checks++;
    if (bus.rd_err !== 1'b0) begin
      errors++;
      $display("FAIL reset rd_err: got %b expected 0", bus.rd_err);
    end
`endif
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_delay();
    do_txn(WR, 4'd3, 8'hA5, 4'd0, "wr_a3_d0");
    do_txn(RD, 4'd3, 8'h00, 4'd0, "rd_a3_d0");
  endtask

  task automatic test_max_delay();
    do_txn(WR, 4'd15, 8'h3C, 4'd15, "wr_a15_d15");
    do_txn(RD, 4'd15, 8'h00, 4'd15, "rd_a15_d15");
    do_txn(RD, 4'd3, 8'h00, 4'(($urandom_range(1, 7))), "rd_a3_rand");
  endtask

  task automatic test_abort();
    bit ack_seen = 0;
    do_txn(WR, 4'd5, 8'h5A, 4'd2, "wr_a5_old");
    bus.address = 4'd5; bus.wr_ni = WR; bus.dataW = 8'h11; bus.delay = 4'd4; bus.rq = 1'b1;
    @(posedge clk);
    repeat (2) begin
      @(negedge clk);
      if (bus.ack === 1'b1) ack_seen = 1;
    end
    bus.rq = 1'b0;
    @(negedge clk);
    checks++;
    if (state_dbg !== IDLE || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort state: state=%0d busy=%b expected IDLE 0", state_dbg, bus.busy);
    end
    repeat (4) begin
      @(negedge clk);
      if (bus.ack === 1'b1) ack_seen = 1;
    end
    checks++;
    if (ack_seen) begin
      errors++;
      $display("FAIL abort ack: got ack=1 expected none");
    end
    do_txn(RD, 4'd5, 8'h00, 4'd1, "rd_a5_after_abort");
  endtask

  task automatic test_back_to_back();
    logic       wr_a[4];
    logic [7:0] d_a[4];
    logic       exp_err;
    logic [7:0] exp_d;
    int         prev = 0;
    bit         seen;
    wr_a[0] = WR; d_a[0] = 8'h77;
    wr_a[1] = RD; d_a[1] = 8'h00;
    wr_a[2] = WR; d_a[2] = 8'hC3;
    wr_a[3] = RD; d_a[3] = 8'h00;
    drive_in(wr_a[0], 4'd0, d_a[0], 4'd1, exp_err);
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (bus.ack === 1'b1) begin
          seen = 1;
          break;
        end
        if (state_dbg == WAIT) begin
          bus.address = 4'd9;
          bus.dataW   = 8'hFF;
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL b2b txn%0d: no ack within 10 cycles", k);
      end
      if (k > 0) begin
        checks++;
        if (cyc - prev != 3) begin
          errors++;
          $display("FAIL b2b spacing txn%0d: got %0d cycles expected 3", k, cyc - prev);
        end
      end
      prev = cyc;
      if (wr_a[k] == RD) begin
        exp_d = exp_q.pop_front();
        checks++;
        if (bus.dataR !== exp_d) begin
          errors++;
          $display("FAIL b2b read txn%0d: got %h expected %h", k, bus.dataR, exp_d);
        end
      end
      if (k < 3) drive_in(wr_a[k+1], 4'd0, d_a[k+1], 4'd1, exp_err);
      else bus.rq = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b end busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    bus.address = 4'd3; bus.wr_ni = WR; bus.dataW = 8'hEE; bus.delay = 4'd5; bus.rq = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || state_dbg !== IDLE || bus.dataR !== 8'h00) begin
      errors++;
      $display("FAIL mid reset: ack=%b busy=%b state=%0d dataR=%h expected 0 0 0 00",
               bus.ack, bus.busy, state_dbg, bus.dataR);
    end
    bus.rq = 1'b0;
    for (int i = 0; i < 16; i++) model_valid[i] = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_txn(RD, 4'd3, 8'h00, 4'd0, "rd_a3_after_reset");
  endtask

  task automatic test_uninit();
`ifdef RAM_SLAVE_UNINIT_CHK_EN
    do_txn(RD, 4'd9, 8'h00, 4'd0, "rd_a9_uninit");
    do_txn(WR, 4'd9, 8'h42, 4'd2, "wr_a9");
    do_txn(RD, 4'd9, 8'h00, 4'd0, "rd_a9_valid");
`else
    do_txn(WR, 4'd9, 8'h42, 4'd2, "wr_a9");
    do_txn(RD, 4'd9, 8'h00, 4'd0, "rd_a9");
`endif
  endtask

  initial begin
    test_reset();
    test_zero_delay();
    test_max_delay();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_uninit();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: %0d expected reads left unconsumed, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
